uart_rx: RTL
============

# uart_rx

Serial UART receiver for the on-chip UART peripheral at 0x1000000–0x1000004, the receive-side counterpart of the existing transmitter. It oversamples the asynchronous `rx` pin with the system clock, recovers 8N1 frames at the configured baud rate, and presents each byte through a one-entry holding register with a valid/ready handshake toward the UART register interface. Framing errors and overruns are reported as sticky flags.

## Interface
- `clks_per_bit`, default `clks_per_bit` from configure (20 MHz / 115200 − 1 = 172): bit period minus one, in clock cycles.
- `reset`  in  1  asynchronous, active-low reset.
- `clock`  in  1  system clock; all logic is rising-edge.
- `rx`  in  1  serial input. Idle high. Asynchronous to `clock`.
- `rx_data`  out  8  received byte. Valid while `rx_valid`=1.
- `rx_valid`  out  1  holding register is full.
- `rx_ready`  in  1  consumer takes the byte in any cycle where `rx_valid` && `rx_ready`.
- `frame_err`  out  1  sticky; a stop bit was sampled low.
- `overrun`  out  1  sticky; a byte completed while the holding register was full.
- `clear`  in  1  synchronous clear of `frame_err` and `overrun`.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1. The FSM uses only `rx_s`.
- **Bit-timing counter.** `cnt`, width $clog2(clks_per_bit+1). Cleared on every state change.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rx_s`=0, go to START with `cnt`=0.
  - START: increment `cnt`. When `cnt` == `clks_per_bit`/2 (integer division), sample `rx_s`.
    - Sample 1: false start; return to IDLE.
    - Sample 0: go to DATA with `cnt`=0 and `bit_idx`=0.
  - DATA: increment `cnt`. When `cnt` == `clks_per_bit`, sample `rx_s` into shift[`bit_idx`] (LSB first) and clear `cnt`.
    - After bit 7, go to STOP.
  - STOP: when `cnt` == `clks_per_bit`, sample `rx_s`.
    - Sample 1: deliver the byte and go to IDLE.
    - Sample 0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- **Delivery, evaluated in the stop-sample cycle.**
  - Holding register empty, or being consumed this cycle (`rx_valid` && `rx_ready`): load `rx_data` and keep or raise `rx_valid`.
  - Holding register full and not consumed: set `overrun`, drop the new byte, keep the old one.
- **Handshake.** `rx_valid` falls the cycle after `rx_valid` && `rx_ready`, unless a new byte loads in that same cycle.
- **Sticky flags.** If `clear` and a new set event occur in the same cycle, the set wins.
- **Reset values.** `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, state=IDLE, `cnt`=0, `bit_idx`=0, synchronizer flops = 1.
- **Reset mid-frame.** The frame is abandoned. After release the FSM is in IDLE; if the line is still mid-frame, the next low bit may start a spurious frame. That case is accepted.

## Timing
- Bit period is `clks_per_bit`+1 cycles. The start sample falls at half period; data samples are at bit centres.
- Pin-to-`rx_s` delay is 2 cycles.
- Let T be the cycle in which IDLE sees `rx_s`=0:
  - start sample at T+1+`clks_per_bit`/2;
  - data bit n sampled (n+1)·(`clks_per_bit`+1) cycles later;
  - stop sample at T+1+`clks_per_bit`/2+9·(`clks_per_bit`+1).
- `rx_valid`, `frame_err` and `overrun` update on the edge ending the stop-sample cycle, i.e. visible the following cycle.
- Back-to-back frames with no idle gap are supported. IDLE is re-entered one cycle after the stop sample, half a bit before the next start edge.
- Tolerated baud mismatch is about ±4% for 10-bit frames.

## Test plan
All directed tests use `clks_per_bit`=15 (bit period 16 cycles, half sample at `cnt`=7).
- **Single byte.** Drive 0xA5 as 8N1 with `rx_ready`=0. Required: `rx_valid` rises exactly 2+1+7+9·16+1 cycles after the pin falls, `rx_data`=0xA5, both flags 0.
- **Back-to-back bytes.** Send 0x00 then 0xFF with no gap, with `rx_ready` pulsed on each `rx_valid`. Required: both bytes delivered in order, no errors.
- **Overrun.** Send 0x11 then 0x22 with `rx_ready`=0. Required: `rx_data` stays 0x11, `overrun`=1. Pulse `clear`: `overrun`=0.
- **Simultaneous consume.** Assert `rx_ready` in the cycle the second byte's stop sample occurs. Required: `rx_data`=0x22, `rx_valid` stays 1, `overrun`=0.
- **Frame error and break.** Send a frame with stop bit 0 and the line then held low for 100 cycles. Required: `frame_err`=1, `rx_valid`=0, no further bytes until the line returns high; a following 0x3C is received correctly.
- **Glitch and reset.** A 4-cycle low glitch (false start) produces no byte. Asserting `reset` in mid-DATA returns every output to its reset value.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the asynchronous rx pin, recovers frames and
// presents each byte through a one-entry valid/ready holding register.
`timescale 1ns/1ps
module uart_rx #(
   parameter int clks_per_bit = 172
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   input  logic       clear
);

   localparam int cnt_w = $clog2(clks_per_bit + 1);
   localparam logic [cnt_w-1:0] cnt_full = cnt_w'(clks_per_bit);
   localparam logic [cnt_w-1:0] cnt_half = cnt_w'(clks_per_bit / 2);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t           state, state_next;
   logic [cnt_w-1:0] cnt, cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shift;
   logic             rx_meta, rx_s;
   logic             sample_bit, stop_ok, stop_bad;

   // Synchronizer flops reset high so an idle line is never seen as a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values, which is what makes the two stages a pipeline.
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      sample_bit   = 1'b0;
      stop_ok      = 1'b0;
      stop_bad     = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         START: begin
            if (cnt == cnt_half) begin
               cnt_next = '0;
               if (rx_s) begin
                  state_next = IDLE;
               end else begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == cnt_full) begin
               sample_bit   = 1'b1;
               cnt_next     = '0;
               bit_idx_next = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_next = STOP;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == cnt_full) begin
               cnt_next = '0;
               if (rx_s) begin
                  stop_ok    = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_bad   = 1'b1;
                  state_next = BREAK;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         BREAK: begin
            // Wait for the line to return high so a held-low line is not
            // decoded as a stream of 0x00 frames.
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (sample_bit) shift[bit_idx] <= rx_s;

         // Set events are written after clear so they win in the same cycle.
         if (clear) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         if (stop_bad) frame_err <= 1'b1;

         if (stop_ok) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
